// File: rtl/rr_arb4_sched_pkg.sv
// rr_arb4_pkg: shared types, constants and helpers for the 4-way round-robin scheduler.
package rr_arb4_pkg;
  localparam int NREQ = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1, GAP = 2'd2} state_e;
  function automatic logic [1:0] onehot2idx(input logic [NREQ-1:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction
endpackage

// File: rtl/rr_arb4_sched_if.sv
// rr_arb4_sched_if: request/grant bundle between requesters and the scheduler.
interface rr_arb4_sched_if;
  import rr_arb4_pkg::*;
  logic [NREQ-1:0] REQ;
  logic [NREQ-1:0] GNT;
  logic [1:0]      GNT_ID;
  logic            BUSY;
  logic            PREEMPT;
  modport master (output REQ, input GNT, GNT_ID, BUSY, PREEMPT);
  modport slave  (input REQ, output GNT, GNT_ID, BUSY, PREEMPT);
endinterface

// File: rtl/rr_pick4.sv
// rr_pick4: first set request at or above ptr_i, wrapping modulo 4.
module rr_pick4 (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [1:0] win_id_o,
  output logic       any_o
);
  logic [1:0] p1, p2, p3;
  assign p1 = ptr_i + 2'd1;
  assign p2 = ptr_i + 2'd2;
  assign p3 = ptr_i + 2'd3;
  assign any_o = |req_i;
  assign win_id_o = req_i[ptr_i] ? ptr_i : req_i[p1] ? p1 : req_i[p2] ? p2 : p3;
endmodule

// File: rtl/rr_arb4_sched.sv
// rr_arb4_sched: round-robin owner selection for a shared AND-reduction slice,
// with bounded tenure and a one-cycle turnaround between successive owners.
module rr_arb4_sched
  import rr_arb4_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int CW       = 8
) (
  input logic CLK,
  input logic RST,
  rr_arb4_sched_if.slave bus
);
  state_e          state_q;
  logic [1:0]      ptr_q;
  logic [CW-1:0]   cnt_q;
  logic [NREQ-1:0] gnt_q;
  logic [1:0]      gnt_id_q;
  logic            busy_q;
  logic            preempt_q;
  logic [1:0]      win_id;
  logic [1:0]      own_id;
  logic            any;
  logic            expire;
  logic            others;
  logic            keep;
  rr_pick4 u_pick (
    .req_i   (bus.REQ),
    .ptr_i   (ptr_q),
    .win_id_o(win_id),
    .any_o   (any)
  );
  assign own_id = onehot2idx(gnt_q);
  assign others = |(bus.REQ & ~gnt_q);
  assign expire = cnt_q == CW'(HOLD_MAX - 1);
  assign keep   = bus.REQ[own_id];
  // A release (owner drops REQ) takes precedence over expiry, so PREEMPT only flags forced hand-offs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      busy_q    <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      preempt_q <= 1'b0;
      case (state_q)
        OWN: begin
          if (!keep || (expire && others)) begin
            state_q   <= GAP;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            busy_q    <= 1'b0;
            preempt_q <= keep;
            ptr_q     <= own_id + 2'd1;
            cnt_q     <= '0;
          end else begin
            cnt_q <= expire ? '0 : cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= any ? OWN : IDLE;
          gnt_q    <= any ? NREQ'(1) << win_id : '0;
          gnt_id_q <= any ? win_id : 2'd0;
          busy_q   <= any;
          cnt_q    <= '0;
        end
      endcase
    end
  end
  assign bus.GNT     = gnt_q;
  assign bus.GNT_ID  = gnt_id_q;
  assign bus.BUSY    = busy_q;
  assign bus.PREEMPT = preempt_q;
endmodule
